// File: rtl/program_counter.sv
// program_counter: architectural PC register for the single-cycle RV32I core.
// Captures the next-PC mux output on every rising clk edge and presents it as
// the instruction fetch address. Reset is asynchronous, active-low, and forces
// the boot vector. Stores Next_PC bit-exact: no alignment masking or arithmetic.
//
// Optional build macro: PC_STALL_EN
//   Adds input pc_en. 1 = load Next_PC, 0 = hold. Reset still overrides it.
//   When undefined, the port list is exactly clk, reset, Next_PC, Current_PC.
module program_counter #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
`ifdef PC_STALL_EN
  input  logic            pc_en,
`endif
  input  logic [XLEN-1:0] Next_PC,
  output logic [XLEN-1:0] Current_PC
);

  logic            w_load;
  logic [XLEN-1:0] r_pc;

`ifdef PC_STALL_EN
  assign w_load = pc_en;
`else
  assign w_load = 1'b1;
`endif

  // PC register: async reset to the boot vector, otherwise load on enabled edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_pc <= RESET_VECTOR;
    else if (w_load) r_pc <= Next_PC;
  end

  assign Current_PC = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed plus randomized checks of the PC register
// against a one-variable behavioural model (value last accepted by the PC).
module tb_program_counter;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Next_PC = 32'h0;
  logic [31:0] Current_PC;
`ifdef PC_STALL_EN
  logic        pc_en = 1'b1;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] m_pc;   // model: what the PC should hold

  program_counter #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef PC_STALL_EN
    .pc_en      (pc_en),
`endif
    .Next_PC    (Next_PC),
    .Current_PC (Current_PC)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #2;                       // between edges
    reset = 1'b0; Next_PC = 32'h40;
    m_pc = RV;
    #1;
    total++;
    if (Current_PC !== m_pc) begin
      bad++; $display("FAIL reset_async got=%h exp=%h", Current_PC, m_pc);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (Current_PC !== m_pc) begin
        bad++; $display("FAIL reset_hold%0d got=%h exp=%h", i, Current_PC, m_pc);
      end
    end
  endtask

  // Present v at a negedge, release reset if held, check after the next edge
  task automatic load(input logic [31:0] v, input string nm);
    @(negedge clk);
    reset = 1'b1;
    Next_PC = v;
    @(posedge clk); #1;
    m_pc = v;
    total++;
    if (Current_PC !== m_pc) begin
      bad++; $display("FAIL %s got=%h exp=%h", nm, Current_PC, m_pc);
    end
  endtask

  task automatic test_unaligned();
    load(32'd15, "unaligned15");
    load(32'd19, "unaligned19");
  endtask

  task automatic test_sequence();
    logic [31:0] prev;
    for (int i = 0; i < 4; i++) begin
      prev = m_pc;
      @(negedge clk);
      Next_PC = 32'(i * 4);
      #2;
      Next_PC = 32'hDEAD_BEE0;  // mid-cycle wiggle must not reach output
      #1;
      total++;
      if (Current_PC !== prev) begin
        bad++; $display("FAIL seq_comb_path%0d got=%h exp=%h", i, Current_PC, prev);
      end
      Next_PC = 32'(i * 4);
      @(posedge clk); #1;
      m_pc = 32'(i * 4);
      total++;
      if (Current_PC !== m_pc) begin
        bad++; $display("FAIL seq%0d got=%h exp=%h", i, Current_PC, m_pc);
      end
    end
  endtask

  task automatic test_wrap();
    load(32'hFFFF_FFFC, "wrap_top");
    load(32'h0, "wrap_zero");
  endtask

  task automatic test_midreset();
    load(32'h100, "midreset_pre");
    @(negedge clk);
    Next_PC = 32'h300;
    #2;
    reset = 1'b0;
    m_pc = RV;
    #1;
    total++;
    if (Current_PC !== m_pc) begin
      bad++; $display("FAIL midreset_async got=%h exp=%h", Current_PC, m_pc);
    end
    load(32'h200, "midreset_release");
  endtask

  task automatic test_coincident();
    load(32'h44, "coinc_pre");
    @(negedge clk);
    Next_PC = 32'h88;
    @(posedge clk);
    reset = 1'b0;           // same time step as the edge
    m_pc = RV;
    #1;
    total++;
    if (Current_PC !== m_pc) begin
      bad++; $display("FAIL coincident got=%h exp=%h", Current_PC, m_pc);
    end
    Next_PC = 32'bx;        // X input while in reset must be ignored
    @(posedge clk); #1;
    total++;
    if (Current_PC !== m_pc) begin
      bad++; $display("FAIL reset_x_input got=%h exp=%h", Current_PC, m_pc);
    end
    load(32'h4, "coinc_release");
  endtask

`ifdef PC_STALL_EN
  task automatic test_stall();
    load(32'd8, "stall_pre");
    @(negedge clk);
    pc_en = 1'b0; Next_PC = 32'd12;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (Current_PC !== m_pc) begin
        bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, Current_PC, m_pc);
      end
    end
    @(negedge clk);
    pc_en = 1'b1;
    @(posedge clk); #1;
    m_pc = 32'd12;
    total++;
    if (Current_PC !== m_pc) begin
      bad++; $display("FAIL stall_release got=%h exp=%h", Current_PC, m_pc);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] v;
    logic        en;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      v  = $urandom;
      en = 1'b1;
`ifdef PC_STALL_EN
      en = ($urandom_range(0, 3) != 0);
      pc_en = en;
`endif
      Next_PC = v;
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        m_pc = RV;
        #1;
        total++;
        if (Current_PC !== m_pc) begin
          bad++; $display("FAIL rand_rst%0d got=%h exp=%h", i, Current_PC, m_pc);
        end
      end else begin
        reset = 1'b1;
        if (en) begin
          @(posedge clk);
          m_pc = v;
        end
      end
      @(posedge clk); #1;
      total++;
      if (Current_PC !== m_pc) begin
        bad++; $display("FAIL rand%0d got=%h exp=%h", i, Current_PC, m_pc);
      end
    end
`ifdef PC_STALL_EN
    pc_en = 1'b1;
`endif
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_unaligned();
    test_sequence();
    test_wrap();
    test_midreset();
    test_coincident();
`ifdef PC_STALL_EN
    test_stall();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
